// File: rtl/mem_pkg.sv
// Shared definitions for the byte_addressable memory port: size codes,
// load/store unit state encoding and the alignment check.
package mem_pkg;

  localparam logic [1:0] MEM_SIZE_NONE = 2'd0;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd1;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd2;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELEASE,
    RESPOND
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == MEM_SIZE_HALF) bad = addr_lo[0];
    else if (size == MEM_SIZE_WORD) bad = (addr_lo != 2'b00);
    is_misaligned = bad;
  endfunction

endpackage

// File: rtl/load_data_extend.sv
// Selects byte/half/word read data by access size and sign- or zero-extends
// it to 32 bits. Purely combinational.
module load_data_extend
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [7:0]  byte_data,
  input  logic [15:0] half_data,
  input  logic [31:0] word_data,
  output logic [31:0] data
);

  always_comb begin
    data = word_data;
    case (size)
      MEM_SIZE_BYTE: data = {{24{is_signed & byte_data[7]}}, byte_data};
      MEM_SIZE_HALF: data = {{16{is_signed & half_data[15]}}, half_data};
      default:       data = word_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the byte_addressable memory port.
// Loads complete after a fixed read latency; stores wait for done, then release.
//
// state      | meaning
// IDLE       | waiting for a request; ready unless memory still shows done
// READ_WAIT  | counting down the read latency, then capture extended data
// WRITE_WAIT | write_mode driven, waiting for done / error / timeout
// RELEASE    | write_mode dropped, wait >=2 cycles and for done to clear
// RESPOND    | one-cycle response strobe
module load_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_write_mode,
  output logic [7:0]  mem_write_byte,
  output logic [15:0] mem_write_half_word,
  output logic [31:0] mem_write_word,
  input  logic        mem_done,
  input  logic        mem_error,
  input  logic [7:0]  mem_byte_output,
  input  logic [15:0] mem_half_word_output,
  input  logic [31:0] mem_word_output
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       lat_size;
  logic             lat_signed;
  logic [31:0]      lat_wdata;
  logic [31:0]      ext_data;
  logic             accept, illegal, err_set;

  assign req_ready  = (state == IDLE) && !mem_done;
  assign accept     = req_valid && req_ready;
  assign illegal    = (req_size == MEM_SIZE_NONE) || is_misaligned(req_size, req_address[1:0]);
  assign resp_valid = (state == RESPOND);

  assign mem_write_byte      = lat_wdata[7:0];
  assign mem_write_half_word = lat_wdata[15:0];
  assign mem_write_word      = lat_wdata;

  load_data_extend u_extend (
    .size      (lat_size),
    .is_signed (lat_signed),
    .byte_data (mem_byte_output),
    .half_data (mem_half_word_output),
    .word_data (mem_word_output),
    .data      (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_next = RESPOND;
          end else if (req_write) begin
            state_next = WRITE_WAIT;
            cnt_next   = '0;
          end else begin
            state_next = READ_WAIT;
            cnt_next   = RD_INIT;
          end
        end
      end
      READ_WAIT: begin
        if (cnt == '0) state_next = RESPOND;
        else           cnt_next   = cnt - 1'b1;
      end
      WRITE_WAIT: begin
        if (mem_done || mem_error || (cnt == TO_LAST)) begin
          state_next = RELEASE;
          cnt_next   = '0;
          err_set    = mem_error || (!mem_done && (cnt == TO_LAST));
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RELEASE: begin
        // cnt==0 marks the first RELEASE cycle; a second cycle is always spent
        if ((cnt != '0) && !mem_done) state_next = RESPOND;
        else if (cnt == '0)           cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address    <= '0;
      mem_write_mode <= MEM_SIZE_NONE;
      lat_wdata      <= '0;
      lat_size       <= MEM_SIZE_NONE;
      lat_signed     <= 1'b0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        mem_address    <= req_address;
        lat_wdata      <= req_wdata;
        lat_size       <= req_size;
        lat_signed     <= req_signed;
        resp_rdata     <= '0;
        resp_error     <= illegal;
        mem_write_mode <= (!illegal && req_write) ? req_size : MEM_SIZE_NONE;
      end
      if (state == READ_WAIT && cnt == '0) resp_rdata <= ext_data;
      if (state == WRITE_WAIT && state_next == RELEASE) begin
        mem_write_mode <= MEM_SIZE_NONE;
        if (err_set) resp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a big-endian byte memory model
// with configurable done delay, done hold, stuck-busy and error injection.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [1:0]  mem_write_mode;
  logic [7:0]  mem_write_byte;
  logic [15:0] mem_write_half_word;
  logic [31:0] mem_write_word;
  logic        mem_done = 1'b0;
  logic        mem_error = 1'b0;
  logic [7:0]  mem_byte_output;
  logic [15:0] mem_half_word_output;
  logic [31:0] mem_word_output;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;

  int done_delay = 0;
  int done_hold  = 0;
  bit never_done = 1'b0;
  bit err_with_done = 1'b0;
  int wcnt = 0;
  int hcnt = 0;

  logic [7:0] mem [0:511];
  logic [8:0] ra0, ra1, ra2, ra3;

  always #5 clk = ~clk;

  load_store_unit #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address), .mem_write_mode(mem_write_mode),
    .mem_write_byte(mem_write_byte), .mem_write_half_word(mem_write_half_word),
    .mem_write_word(mem_write_word), .mem_done(mem_done), .mem_error(mem_error),
    .mem_byte_output(mem_byte_output), .mem_half_word_output(mem_half_word_output),
    .mem_word_output(mem_word_output)
  );

  assign ra0 = mem_address[8:0];
  assign ra1 = ra0 + 9'd1;
  assign ra2 = ra0 + 9'd2;
  assign ra3 = ra0 + 9'd3;
  assign mem_byte_output      = mem[ra0];
  assign mem_half_word_output = {mem[ra0], mem[ra1]};
  assign mem_word_output      = {mem[ra0], mem[ra1], mem[ra2], mem[ra3]};

  // Memory: write lands when done rises; done drops done_hold cycles after write_mode clears.
  always @(posedge clk) begin
    mem_error <= 1'b0;
    if (mem_write_mode != 2'd0 && !mem_done) begin
      if (!never_done && wcnt >= done_delay) begin
        case (mem_write_mode)
          2'd1: mem[ra0] <= mem_write_byte;
          2'd2: begin
            mem[ra0] <= mem_write_half_word[15:8];
            mem[ra1] <= mem_write_half_word[7:0];
          end
          default: begin
            mem[ra0] <= mem_write_word[31:24];
            mem[ra1] <= mem_write_word[23:16];
            mem[ra2] <= mem_write_word[15:8];
            mem[ra3] <= mem_write_word[7:0];
          end
        endcase
        mem_done  <= 1'b1;
        mem_error <= err_with_done;
        wcnt      <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else if (mem_done && mem_write_mode == 2'd0) begin
      if (hcnt >= done_hold) begin
        mem_done <= 1'b0;
        hcnt     <= 0;
      end else begin
        hcnt <= hcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  always @(posedge clk) if (resp_valid) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output logic [1:0] mode1, output int mode_cyc);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_address = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    mode1 = mem_write_mode;
    mode_cyc = 0;
    while (!resp_valid && lat < 100) begin
      if (mem_write_mode != 2'd0) mode_cyc++;
      @(negedge clk);
      lat++;
    end
    check("resp_valid_seen", resp_valid, 1);
    rdata = resp_rdata;
    err = resp_error;
    @(negedge clk);
    check("resp_valid_one_cycle", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, mc, p0, t;
    logic [31:0] rd;
    logic er;
    logic [1:0] m1;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_address = '0; req_wdata = '0;
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_write_mode", mem_write_mode, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_error", resp_error, 0);
    rst_n = 1'b1;

    // byte store 0x80 to 0x40
    issue(1'b1, 2'd1, 1'b0, 32'h40, 32'h0000_0080, lat, rd, er, m1, mc);
    check("sb_latency", lat, 5);
    check("sb_error", er, 0);
    check("sb_rdata", rd, 0);
    check("sb_mode", m1, 1);

    issue(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, lat, rd, er, m1, mc);
    check("lb_signed_latency", lat, 3);
    check("lb_signed_rdata", rd, 32'hFFFF_FF80);
    check("lb_signed_error", er, 0);
    check("lb_signed_mode", m1, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h40, 32'h0, lat, rd, er, m1, mc);
    check("lb_unsigned_rdata", rd, 32'h0000_0080);

    // half-word store 0xBEEF to 0x102
    p0 = pulses;
    issue(1'b1, 2'd2, 1'b0, 32'h102, 32'h1234_BEEF, lat, rd, er, m1, mc);
    check("sh_mode", m1, 2);
    check("sh_mode_cycles", mc, 2);
    check("sh_latency", lat, 5);
    check("sh_error", er, 0);
    check("sh_mode_after", mem_write_mode, 0);
    check("sh_pulses", pulses - p0, 1);
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, lat, rd, er, m1, mc);
    check("lw_lower_half", rd[15:0], 16'hBEEF);
    issue(1'b0, 2'd2, 1'b1, 32'h102, 32'h0, lat, rd, er, m1, mc);
    check("lh_signed_rdata", rd, 32'hFFFF_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, lat, rd, er, m1, mc);
    check("lh_unsigned_rdata", rd, 32'h0000_BEEF);

    // illegal accesses
    issue(1'b0, 2'd3, 1'b0, 32'h101, 32'h0, lat, rd, er, m1, mc);
    check("mis_lw_latency", lat, 1);
    check("mis_lw_error", er, 1);
    check("mis_lw_mode", m1, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, lat, rd, er, m1, mc);
    check("size0_error", er, 1);
    check("size0_latency", lat, 1);
    issue(1'b1, 2'd2, 1'b0, 32'h103, 32'hFFFF, lat, rd, er, m1, mc);
    check("mis_sh_error", er, 1);
    check("mis_sh_mode_cycles", mc, 0);
    issue(1'b1, 2'd3, 1'b0, 32'h102, 32'hFFFF_FFFF, lat, rd, er, m1, mc);
    check("mis_sw_error", er, 1);
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, lat, rd, er, m1, mc);
    check("mis_no_write", rd, 32'h0000_BEEF);
    check("legal_after_mis_error", er, 0);

    // store timeout
    never_done = 1'b1;
    issue(1'b1, 2'd3, 1'b0, 32'h1F0, 32'hCAFE_F00D, lat, rd, er, m1, mc);
    never_done = 1'b0;
    check("to_error", er, 1);
    check("to_mode_cycles", mc, 8);
    check("to_latency", lat, 11);
    check("to_mode_after", mem_write_mode, 0);

    // done and error in the same cycle
    err_with_done = 1'b1;
    issue(1'b1, 2'd1, 1'b0, 32'h50, 32'h5A, lat, rd, er, m1, mc);
    err_with_done = 1'b0;
    check("de_error", er, 1);
    check("de_latency", lat, 5);

    // back-to-back stores with a slow-clearing done
    done_hold = 3;
    issue(1'b1, 2'd3, 1'b0, 32'h60, 32'h1122_3344, lat, rd, er, m1, mc);
    check("b2b_first_latency", lat, 8);
    check("b2b_done_low", mem_done, 0);
    issue(1'b1, 2'd3, 1'b0, 32'h64, 32'h5566_7788, lat, rd, er, m1, mc);
    check("b2b_second_error", er, 0);
    done_hold = 0;
    issue(1'b0, 2'd3, 1'b0, 32'h60, 32'h0, lat, rd, er, m1, mc);
    check("b2b_read_first", rd, 32'h1122_3344);
    issue(1'b0, 2'd3, 1'b0, 32'h64, 32'h0, lat, rd, er, m1, mc);
    check("b2b_read_second", rd, 32'h5566_7788);

    // reset while in WRITE_WAIT with done high
    done_delay = 1; done_hold = 4;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_signed = 1'b0;
    req_address = 32'h80; req_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!mem_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_done_seen", mem_done, 1);
    check("rst_mid_mode_before", mem_write_mode, 3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mode", mem_write_mode, 0);
    check("rst_mid_address", mem_address, 0);
    check("rst_mid_resp_valid", resp_valid, 0);
    check("rst_mid_ready_blocked", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready_blocked", req_ready, 0);
    t = 0;
    while (mem_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_rel_done_cleared", mem_done, 0);
    check("rst_rel_ready", req_ready, 1);
    done_delay = 0; done_hold = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator for the `byte_addressable` memory port: accepts one load/store request at a time from the processor datapath, drives the memory's `write_mode`/address/data handshake, and returns one response per request. Loads are timed by a fixed read latency. Stores wait for `done`, then release `write_mode` to 0. The block also sign- or zero-extends load data, rejects misaligned accesses, and times out stalled stores.

## Interface
- READ_LATENCY, 2: cycles from the address being stable to valid memory read data (minimum 1).
- TIMEOUT_CYCLES, 64: maximum cycles in WRITE_WAIT before the store is abandoned with an error.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high when `state==IDLE && !mem_done`.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  1 = byte, 2 = half word, 3 = word, 0 = illegal.
- req_signed  in  1  sign-extend load data.
- req_address  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_error  out  1  misaligned, illegal size, memory error, or timeout.
- mem_address  out  32  registered, latched request address.
- mem_write_mode  out  2  0 = idle/read; otherwise equals the latched size.
- mem_write_byte  out  8  `wdata[7:0]`.
- mem_write_half_word  out  16  `wdata[15:0]`.
- mem_write_word  out  32  `wdata`.
- mem_done, mem_error  in  1 each  memory status.
- mem_byte_output, mem_half_word_output, mem_word_output  in  8/16/32  memory read data.

## Operation
- States: IDLE, READ_WAIT, WRITE_WAIT, RELEASE, RESPOND.
- **IDLE**
  - On `req_valid && req_ready`, latch address, wdata, size, signed and write, and clear the error flag.
  - Illegal request goes directly to RESPOND with the error flag set. Illegal means any of: `size==0`; half word with `addr[0]==1`; word with `addr[1:0]!=0`. No memory access is made.
  - Legal load goes to READ_WAIT with the counter set to READ_LATENCY-1.
  - Legal store goes to WRITE_WAIT with the counter at 0, and `mem_write_mode` is set to the size.
- **READ_WAIT**
  - `mem_write_mode` is 0. The counter decrements each cycle.
  - At counter 0, capture the read data selected by size into `resp_rdata` and go to RESPOND.
  - Extension: bit 7 (byte) or bit 15 (half word) when signed, else zeros. Word data passes through unchanged.
- **WRITE_WAIT**
  - Hold `mem_write_mode` and the data. The counter increments each cycle.
  - `mem_done==1` goes to RELEASE.
  - `mem_error==1`, or counter reaching TIMEOUT_CYCLES-1 without done, sets the error flag and goes to RELEASE.
  - If done and error arrive in the same cycle, the store completes with the error flag set.
- **RELEASE**
  - `mem_write_mode` is 0. Stay for at least 2 cycles, then go to RESPOND on the first cycle where `mem_done==0`.
  - This guarantees the memory has returned to its START state before any new store is issued.
- **RESPOND**
  - `resp_valid=1` for exactly one cycle, with `resp_rdata` and `resp_error` stable, then go to IDLE.
  - `resp_rdata` and `resp_error` hold their values until the next request is accepted.
- There is no back-pressure on the response; the consumer must accept it in that cycle.
- A new request is never accepted in the RESPOND cycle.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state goes to IDLE;
  - `mem_write_mode`, `mem_address`, the write-data outputs, `resp_valid`, `resp_rdata`, `resp_error` and the counters all go to 0;
  - `req_ready` = `!mem_done`.
- Aligned load accepted in cycle N: `resp_valid` in cycle N+1+READ_LATENCY. With the default, N+3.
- Illegal request accepted in cycle N: `resp_valid` with `resp_error=1` in cycle N+1.
- Store accepted in cycle N:
  - `mem_write_mode` is nonzero from N+1 until the cycle after `mem_done` is first seen high;
  - `resp_valid` is at least 3 cycles after that.
- Reset mid-store forces `mem_write_mode` to 0 at once. The `!mem_done` gate on `req_ready` blocks a new request until the memory's `done` clears.
- `mem_address` changes only on request acceptance.

## Structure
- Shared package `mem_pkg` holds:
  - size codes `MEM_SIZE_NONE=0`, `BYTE=1`, `HALF=2`, `WORD=3`;
  - the 3-bit state enumeration;
  - the function `is_misaligned(size, addr[1:0])`.
- Sub-module `load_data_extend`: combinational selection of byte/half/word data plus sign or zero extension. It is also reused by the future instruction-fetch path.

## Test plan
- Signed byte load: memory byte = 0x80, `req_signed=1` -> `resp_rdata=0xFFFFFF80`, `resp_error=0`, `resp_valid` exactly 3 cycles after accept. With `req_signed=0` -> `0x00000080`.
- Half-word store to 0x102, data 0xBEEF: `mem_write_mode=2` is held until done, then drops to 0. A word readback of 0x100 returns the lower half = 0xBEEF. A single `resp_valid` with `resp_error=0`.
- Misaligned word load at 0x101 -> `resp_error=1` in cycle N+1; `mem_write_mode` stays 0 and `mem_address` is not used.
- Memory never asserts `done`, TIMEOUT_CYCLES=8 -> `resp_error=1`, `mem_write_mode` returns to 0 after 8 WRITE_WAIT cycles.
- Back-to-back stores: the second request is not accepted until `mem_done` is low, and both writes land.
- Assert `rst_n` low in WRITE_WAIT -> all outputs are 0 in the same cycle; after release, `req_ready` stays low until `mem_done` is 0.
